// File: rtl/rd_seq_ctrl.sv
// Read-sequence controller: device reset, settle wait, then RD_LEN read beats with registered capture.
// Phase lengths come from an external counter block; its counts are checked against the lengths for faults.
module rd_seq_ctrl #(
  parameter int RST_LEN  = 5,
  parameter int WAIT_LEN = 3,
  parameter int RD_LEN   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] rst_cnt,
  input  logic [3:0] wait_st2_cnt,
  input  logic [3:0] rd_st_cnt,
  input  logic [7:0] din,
  output logic       rst_cnt_en,
  output logic       wait_st2_cnt_en,
  output logic       rd_st_cnt_en,
  output logic       dev_rst,
  output logic       rd_en,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST      = 3'd1,
    S_WAIT_ST2 = 3'd2,
    S_RD       = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [3:0] RST_LIM  = 4'(RST_LEN);
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_LEN);
  localparam logic [3:0] RD_LIM   = 4'(RD_LEN);
  localparam logic [3:0] RST_TC   = 4'(RST_LEN - 1);
  localparam logic [3:0] WAIT_TC  = 4'(WAIT_LEN - 1);
  localparam logic [3:0] RD_TC    = 4'(RD_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_vld_q, dout_vld_d;
  logic       fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dout_q     <= 8'h00;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  // A counter already past its phase length means the counter block is out of step with us.
  always_comb begin
    fault = 1'b0;
    case (state_q)
      S_RST:      fault = (rst_cnt >= RST_LIM);
      S_WAIT_ST2: fault = (wait_st2_cnt >= WAIT_LIM);
      S_RD:       fault = (rd_st_cnt >= RD_LIM);
      default:    fault = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RST;
      end
      S_RST: begin
        if (abort || fault)        state_d = S_IDLE;
        else if (rst_cnt == RST_TC) state_d = S_WAIT_ST2;
      end
      S_WAIT_ST2: begin
        if (abort || fault)              state_d = S_IDLE;
        else if (wait_st2_cnt == WAIT_TC) state_d = S_RD;
      end
      S_RD: begin
        if (abort || fault)         state_d = S_IDLE;
        else if (rd_st_cnt == RD_TC) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rst_cnt_en      = 1'b0;
    wait_st2_cnt_en = 1'b0;
    rd_st_cnt_en    = 1'b0;
    dev_rst         = 1'b0;
    rd_en           = 1'b0;
    done            = 1'b0;
    busy            = (state_q != S_IDLE);
    err             = fault;
    case (state_q)
      S_RST: begin
        rst_cnt_en = 1'b1;
        dev_rst    = 1'b1;
      end
      S_WAIT_ST2: wait_st2_cnt_en = 1'b1;
      S_RD: begin
        rd_st_cnt_en = 1'b1;
        rd_en        = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Capture follows rd_en by one edge, so a beat issued just before an abort still lands.
  always_comb begin
    dout_vld_d = rd_en;
    dout_d     = rd_en ? din : dout_q;
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_rd_seq_ctrl.sv
// Randomized bench for rd_seq_ctrl: a phase-timeline reference model checks every cycle of a default
// instance, plus directed checks of a minimum-length instance.
module tb_rd_seq_ctrl;
  localparam int R = 5;
  localparam int W = 3;
  localparam int D = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, ovr;
  logic [7:0] din;
  logic [3:0] c_rst, c_wait, c_rd, rst_cnt_in;
  logic       rst_cnt_en, wait_st2_cnt_en, rd_st_cnt_en, dev_rst, rd_en, dout_vld, busy, done, err;
  logic [7:0] dout;

  logic       start1;
  logic [3:0] c1_rst, c1_wait, c1_rd;
  logic       rce1, wce1, dce1, dev_rst1, rd_en1, dout_vld1, busy1, done1, err1;
  logic [7:0] dout1;

  int         n_cmp = 0;
  int         n_err = 0;
  int         k;          // cycles since entering RST, -1 when idle
  bit         prev_rd;
  logic [7:0] last_din;
  int         busy_cnt, vld_cnt;

  always #5 clk = ~clk;

  assign rst_cnt_in = ovr ? 4'd9 : c_rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rst <= 4'd0; c_wait <= 4'd0; c_rd <= 4'd0;
      c1_rst <= 4'd0; c1_wait <= 4'd0; c1_rd <= 4'd0;
    end else begin
      c_rst   <= rst_cnt_en      ? c_rst + 4'd1   : 4'd0;
      c_wait  <= wait_st2_cnt_en ? c_wait + 4'd1  : 4'd0;
      c_rd    <= rd_st_cnt_en    ? c_rd + 4'd1    : 4'd0;
      c1_rst  <= rce1 ? c1_rst + 4'd1  : 4'd0;
      c1_wait <= wce1 ? c1_wait + 4'd1 : 4'd0;
      c1_rd   <= dce1 ? c1_rd + 4'd1   : 4'd0;
    end
  end

  rd_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rst_cnt(rst_cnt_in), .wait_st2_cnt(c_wait), .rd_st_cnt(c_rd), .din(din),
    .rst_cnt_en(rst_cnt_en), .wait_st2_cnt_en(wait_st2_cnt_en), .rd_st_cnt_en(rd_st_cnt_en),
    .dev_rst(dev_rst), .rd_en(rd_en), .dout(dout), .dout_vld(dout_vld),
    .busy(busy), .done(done), .err(err)
  );

  rd_seq_ctrl #(.RST_LEN(1), .WAIT_LEN(1), .RD_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
    .rst_cnt(c1_rst), .wait_st2_cnt(c1_wait), .rd_st_cnt(c1_rd), .din(din),
    .rst_cnt_en(rce1), .wait_st2_cnt_en(wce1), .rd_st_cnt_en(dce1),
    .dev_rst(dev_rst1), .rd_en(rd_en1), .dout(dout1), .dout_vld(dout_vld1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: timeout, observed no progress expected model phase reached", tag);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);      chk("rst_dev_rst", dev_rst, 0);
    chk("rst_rd_en", rd_en, 0);    chk("rst_dout", dout, 8'h00);
    chk("rst_vld", dout_vld, 0);   chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ens", {rst_cnt_en, wait_st2_cnt_en, rd_st_cnt_en}, 0);
  endtask

  // One clock cycle: apply inputs, check outputs against the timeline model, advance the model.
  task automatic tick(input logic s, input logic a);
    bit e_rst, e_wait, e_rd, e_done, e_err, e_busy;
    start = s;
    abort = a;
    din   = 8'($urandom);
    @(negedge clk);
    e_busy = (k >= 0);
    e_rst  = (k >= 0) && (k < R);
    e_wait = (k >= R) && (k < R + W);
    e_rd   = (k >= R + W) && (k < R + W + D);
    e_done = (k == R + W + D);
    e_err  = ovr && e_rst;
    chk("busy", busy, e_busy);
    chk("dev_rst", dev_rst, e_rst);
    chk("rst_cnt_en", rst_cnt_en, e_rst);
    chk("wait_en", wait_st2_cnt_en, e_wait);
    chk("rd_st_cnt_en", rd_st_cnt_en, e_rd);
    chk("rd_en", rd_en, e_rd);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("dout_vld", dout_vld, prev_rd);
    chk("dout", dout, last_din);
    if (busy) busy_cnt++;
    if (dout_vld) vld_cnt++;
    prev_rd = e_rd;
    if (e_rd) last_din = din;
    if (k < 0)                        k = s ? 0 : -1;
    else if (e_done)                  k = -1;
    else if (a || e_err)              k = -1;
    else                              k = k + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target, input string tag);
    int n = 0;
    while (k != target && n < 50) begin
      tick(1'b0, 1'b0);
      n++;
    end
    if (k != target) timeout(tag);
  endtask

  initial begin
    logic [7:0] cap;
    rst = 1'b1; start = 1'b0; abort = 1'b0; ovr = 1'b0; start1 = 1'b0; din = 8'h00;
    k = -1; prev_rd = 0; last_din = 8'h00;
    #1;
    chk_reset_vals();
    #12;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // nominal sequence: 14 busy cycles, 5 beats
    busy_cnt = 0; vld_cnt = 0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 17; i++) tick(1'b0, 1'b0);
    chk("nom_busy_cycles", busy_cnt, R + W + D + 1);
    chk("nom_beats", vld_cnt, D);

    // abort in the 3rd RD cycle
    vld_cnt = 0;
    tick(1'b1, 1'b0);
    run_to(R + W + 2, "abort_reach");
    tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    chk("abort_beats", vld_cnt, 3);

    // abort in IDLE is harmless
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // asynchronous reset in WAIT_ST2
    tick(1'b1, 1'b0);
    run_to(R + 1, "wait_reach");
    start = 1'b0; abort = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals();
    k = -1; prev_rd = 0; last_din = 8'h00;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    busy_cnt = 0; vld_cnt = 0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b0);
    chk("post_rst_busy", busy_cnt, R + W + D + 1);
    chk("post_rst_beats", vld_cnt, D);

    // faulty counter reads 9 in RST
    ovr = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    ovr = 1'b0;
    tick(1'b0, 1'b0);

    // start held high: back-to-back sequences
    for (int i = 0; i < 45; i++) tick(1'b1, 1'b0);
    run_to(-1, "held_drain");
    tick(1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    run_to(-1, "rand_drain");

    // minimum lengths: one cycle per phase, done on 4th cycle
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cap = 8'h00;
    for (int c = 1; c <= 5; c++) begin
      din = 8'($urandom);
      @(negedge clk);
      chk("min_dev_rst", dev_rst1, c == 1);
      chk("min_wait_en", wce1, c == 2);
      chk("min_rd_en", rd_en1, c == 3);
      chk("min_done", done1, c == 4);
      chk("min_vld", dout_vld1, c == 4);
      chk("min_busy", busy1, c <= 4);
      chk("min_err", err1, 0);
      chk("min_rce", rce1, c == 1);
      chk("min_dce", dce1, c == 3);
      if (c == 3) cap = din;
      if (c >= 4) chk("min_dout", dout1, cap);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
